// File: rtl/exp_taylor_pipe.sv
// exp_taylor_pipe
// Fully pipelined fixed-point exp(x) = 1 + sum_{k=1..N_TERMS} x^k/k!, one sample per cycle.
// Each stage derives the next Taylor term from the previous one:
//   t_k = ((t_{k-1} * x) >>> FRAC_W) / k
// so no coefficient table is needed. Terms and sums are ACC_W = DATA_W+8 bits, signed.
//
// Ports (AXI-Stream in/out, TUSER travels with its sample):
//   aclk                 clock, rising edge
//   aresetn              asynchronous reset, ACTIVE-HIGH despite the name
//   s_axis_data_tdata    signed input x, FRAC_W fractional bits
//   s_axis_data_tuser    opaque sideband
//   s_axis_data_tvalid   input valid
//   s_axis_data_tready   input ready (combinational, equals the global advance)
//   m_axis_data_tdata    exp(x), FRAC_W fractional bits
//   m_axis_data_tuser    sideband aligned with m_axis_data_tdata
//   m_axis_data_tvalid   output valid
//   m_axis_data_tready   output ready
//
// Build option: define EXP_SAT_EN to clamp the result to [0, 2^(DATA_W-1)-1];
// otherwise the result wraps modulo 2^DATA_W.
// Latency: N_TERMS+1 cycles. Backpressure stalls every stage at once (no bubble collapsing).

module exp_taylor_pipe #(
   parameter int DATA_W  = 32,
   parameter int FRAC_W  = 12,
   parameter int N_TERMS = 6,
   parameter int USER_W  = 1
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic signed [DATA_W-1:0] s_axis_data_tdata,
   input  logic        [USER_W-1:0] s_axis_data_tuser,
   input  logic                     s_axis_data_tvalid,
   output logic                     s_axis_data_tready,
   output logic        [DATA_W-1:0] m_axis_data_tdata,
   output logic        [USER_W-1:0] m_axis_data_tuser,
   output logic                     m_axis_data_tvalid,
   input  logic                     m_axis_data_tready
);

   localparam int ACC_W  = DATA_W + 8;
   localparam int PROD_W = ACC_W + DATA_W;

   localparam logic signed [ACC_W-1:0] L_ONE = ACC_W'(1) << FRAC_W;
`ifdef EXP_SAT_EN
   localparam logic signed [ACC_W-1:0] L_SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
`endif

   generate
      if (N_TERMS < 2 || N_TERMS > 12) begin : g_bad_n_terms
         $error("exp_taylor_pipe: N_TERMS must be in 2..12");
      end
   endgenerate

   // Stage s holds term t_{s+1} and partial sum sum_{s+1}. The last stage's term and x are
   // never consumed downstream, so x and t are only kept for stages 0..N_TERMS-2.
   logic signed [DATA_W-1:0] r_x   [N_TERMS-1];
   logic signed [ACC_W-1:0]  r_t   [N_TERMS-1];
   logic signed [ACC_W-1:0]  r_sum [N_TERMS];
   logic        [USER_W-1:0] r_user[N_TERMS];
   logic        [N_TERMS-1:0] r_vld;

   logic        [DATA_W-1:0] r_m_data;
   logic        [USER_W-1:0] r_m_user;
   logic                     r_m_vld;

   logic                     w_adv;
   logic signed [ACC_W-1:0]  w_term [1:N_TERMS-1];
   logic signed [ACC_W-1:0]  w_r;
   logic        [DATA_W-1:0] w_out;

   assign w_adv              = !r_m_vld || m_axis_data_tready;
   assign s_axis_data_tready = w_adv;

   // Term recurrence for stage g, computing t_{g+1} from stage g-1.
   generate
      for (genvar g = 1; g < N_TERMS; g++) begin : g_stage
         localparam logic signed [PROD_W-1:0] L_DIV = PROD_W'(g + 1);
         logic signed [PROD_W-1:0] w_prod;
         logic signed [PROD_W-1:0] w_quo;

         assign w_prod = $signed({{DATA_W{r_t[g-1][ACC_W-1]}}, r_t[g-1]})
                       * $signed({{ACC_W{r_x[g-1][DATA_W-1]}}, r_x[g-1]});
         // Signed '/' truncates toward zero, as the term sequence requires.
         assign w_quo     = (w_prod >>> FRAC_W) / L_DIV;
         assign w_term[g] = ACC_W'(w_quo);
      end
   endgenerate

   assign w_r = r_sum[N_TERMS-1] + L_ONE;

   always_comb begin
`ifdef EXP_SAT_EN
      // A negative result can only come from series divergence; exp is never negative.
      if (w_r > L_SAT_MAX) begin
         w_out = DATA_W'(L_SAT_MAX);
      end else if (w_r[ACC_W-1]) begin
         w_out = '0;
      end else begin
         w_out = DATA_W'(w_r);
      end
`else
      w_out = DATA_W'(w_r);
`endif
   end

   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_vld <= '0;
         for (int i = 0; i < N_TERMS; i++) begin
            r_sum[i]  <= '0;
            r_user[i] <= '0;
         end
         for (int i = 0; i < N_TERMS - 1; i++) begin
            r_x[i] <= '0;
            r_t[i] <= '0;
         end
         r_m_data <= '0;
         r_m_user <= '0;
         r_m_vld  <= 1'b0;
      end else if (w_adv) begin
         // s_tready equals w_adv here, so the accept condition reduces to tvalid.
         r_vld[0]  <= s_axis_data_tvalid;
         r_user[0] <= s_axis_data_tuser;
         r_x[0]    <= s_axis_data_tdata;
         r_t[0]    <= ACC_W'(s_axis_data_tdata);
         r_sum[0]  <= ACC_W'(s_axis_data_tdata);
         for (int i = 1; i < N_TERMS; i++) begin
            r_sum[i]  <= r_sum[i-1] + w_term[i];
            r_user[i] <= r_user[i-1];
            r_vld[i]  <= r_vld[i-1];
         end
         for (int i = 1; i < N_TERMS - 1; i++) begin
            r_t[i] <= w_term[i];
            r_x[i] <= r_x[i-1];
         end
         r_m_data <= w_out;
         r_m_user <= r_user[N_TERMS-1];
         r_m_vld  <= r_vld[N_TERMS-1];
      end
   end

   assign m_axis_data_tdata  = r_m_data;
   assign m_axis_data_tuser  = r_m_user;
   assign m_axis_data_tvalid = r_m_vld;

endmodule

// File: tb/tb_exp_taylor_pipe.sv
// Self-checking bench for exp_taylor_pipe at default parameters.
// Expected results come from exp_model, a straight loop over the Taylor recurrence.

module tb_exp_taylor_pipe;

   localparam int DATA_W  = 32;
   localparam int FRAC_W  = 12;
   localparam int N_TERMS = 6;
   localparam int USER_W  = 1;
   localparam int LAT     = N_TERMS + 1;

   logic                     clk = 1'b0;
   logic                     aresetn;
   logic signed [DATA_W-1:0] s_tdata;
   logic        [USER_W-1:0] s_tuser;
   logic                     s_tvalid;
   logic                     s_tready;
   logic        [DATA_W-1:0] m_tdata;
   logic        [USER_W-1:0] m_tuser;
   logic                     m_tvalid;
   logic                     m_tready;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [USER_W-1:0] u;
   } exp_t;

   always #5 clk = ~clk;

   exp_taylor_pipe #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .N_TERMS(N_TERMS),
      .USER_W (USER_W)
   ) dut (
      .aclk              (clk),
      .aresetn           (aresetn),
      .s_axis_data_tdata (s_tdata),
      .s_axis_data_tuser (s_tuser),
      .s_axis_data_tvalid(s_tvalid),
      .s_axis_data_tready(s_tready),
      .m_axis_data_tdata (m_tdata),
      .m_axis_data_tuser (m_tuser),
      .m_axis_data_tvalid(m_tvalid),
      .m_axis_data_tready(m_tready)
   );

   // exp(x) in Q(FRAC_W): 40-bit terms and sums, 72-bit products, truncating division.
   function automatic logic [31:0] exp_model(input logic signed [31:0] x);
      logic signed [39:0] t;
      logic signed [39:0] sum;
      logic signed [39:0] r;
      logic signed [71:0] a;
      logic signed [71:0] b;
      logic signed [71:0] p;
      logic signed [71:0] q;
      t   = 40'(x);
      sum = 40'(x);
      for (int k = 2; k <= N_TERMS; k++) begin
         a   = 72'(t);
         b   = 72'(x);
         p   = a * b;
         q   = (p >>> FRAC_W) / 72'(k);
         t   = q[39:0];
         sum = sum + t;
      end
      r = sum + 40'sd4096;
`ifdef EXP_SAT_EN
      if (r > 40'sh007FFFFFFF) return 32'h7FFFFFFF;
      if (r[39]) return 32'h0;
`endif
      return r[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      aresetn  = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tuser  = '0;
      m_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (m_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL reset_tvalid: got %0b expected 0", m_tvalid);
      end
      n_tests++;
      if (m_tdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_tdata: got %0h expected 0", m_tdata);
      end
      n_tests++;
      if (m_tuser !== 1'b0) begin
         n_fail++; $display("FAIL reset_tuser: got %0b expected 0", m_tuser);
      end
      aresetn = 1'b0;
      #1;
      n_tests++;
      if (s_tready !== 1'b1) begin
         n_fail++; $display("FAIL reset_tready: got %0b expected 1", s_tready);
      end
      tick();
   endtask

   task automatic test_single_values();
      logic signed [31:0] xs[3];
      logic [31:0]        ex[3];
      int                 lat;
      xs = '{32'sd0, 32'sd4096, -32'sd4096};
      ex = '{32'd4096, 32'd11131, 32'd1507};
      for (int i = 0; i < 3; i++) begin
         m_tready = 1'b1;
         s_tvalid = 1'b1;
         s_tdata  = xs[i];
         s_tuser  = 1'(i & 1);
         #1;
         n_tests++;
         if (s_tready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready[%0d]: got %0b expected 1", i, s_tready);
         end
         tick();
         s_tvalid = 1'b0;
         lat = 1;
         while (!m_tvalid && lat < 20) begin
            tick();
            lat++;
         end
         n_tests++;
         if (lat !== LAT) begin
            n_fail++; $display("FAIL single_latency[%0d]: got %0d expected %0d", i, lat, LAT);
         end
         n_tests++;
         if (m_tdata !== ex[i]) begin
            n_fail++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, m_tdata, ex[i]);
         end
         n_tests++;
         if (m_tuser !== 1'(i & 1)) begin
            n_fail++; $display("FAIL single_user[%0d]: got %0b expected %0b", i, m_tuser, i & 1);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic signed [31:0] xs[3];
      logic [31:0]        ex[3];
      logic               us[3];
      int                 idx_in;
      int                 n_out;
      int                 stall_cnt;
      logic [31:0]        held_d;
      logic               held_u;
      xs = '{32'sd0, 32'sd4096, -32'sd4096};
      ex = '{32'd4096, 32'd11131, 32'd1507};
      us = '{1'b1, 1'b0, 1'b1};
      idx_in = 0; n_out = 0; stall_cnt = 0; held_d = '0; held_u = 1'b0;
      for (int c = 0; c < 40 && n_out < 3; c++) begin
         s_tvalid = (idx_in < 3);
         s_tdata  = (idx_in < 3) ? xs[idx_in] : 32'sd0;
         s_tuser  = (idx_in < 3) ? us[idx_in] : 1'b0;
         m_tready = !(n_out == 1 && stall_cnt < 3);
         #1;
         if (m_tvalid && !m_tready) begin
            n_tests++;
            if (s_tready !== 1'b0) begin
               n_fail++; $display("FAIL b2b_stall_ready: got %0b expected 0", s_tready);
            end
            if (stall_cnt > 0) begin
               n_tests++;
               if (m_tdata !== held_d || m_tuser !== held_u) begin
                  n_fail++;
                  $display("FAIL b2b_stall_hold: got %0d/%0b expected %0d/%0b",
                           m_tdata, m_tuser, held_d, held_u);
               end
            end
            held_d = m_tdata;
            held_u = m_tuser;
            stall_cnt++;
         end
         if (m_tvalid && m_tready) begin
            n_tests++;
            if (m_tdata !== ex[n_out] || m_tuser !== us[n_out]) begin
               n_fail++;
               $display("FAIL b2b_out[%0d]: got %0d/%0b expected %0d/%0b",
                        n_out, m_tdata, m_tuser, ex[n_out], us[n_out]);
            end
            n_out++;
         end
         if (s_tvalid && s_tready) idx_in++;
         tick();
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      n_tests++;
      if (n_out !== 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d expected 3", n_out);
      end
      n_tests++;
      if (stall_cnt !== 3) begin
         n_fail++; $display("FAIL b2b_stall_cycles: got %0d expected 3", stall_cnt);
      end
      tick();
   endtask

   task automatic test_saturation();
      logic signed [31:0] xs[2];
      logic [31:0]        exp_d;
      int                 lat;
      xs = '{32'sd131072, -32'sd131072};
      for (int i = 0; i < 2; i++) begin
         exp_d    = exp_model(xs[i]);
         m_tready = 1'b1;
         s_tvalid = 1'b1;
         s_tdata  = xs[i];
         s_tuser  = 1'b1;
         tick();
         s_tvalid = 1'b0;
         lat = 1;
         while (!m_tvalid && lat < 20) begin
            tick();
            lat++;
         end
         n_tests++;
         if (lat !== LAT) begin
            n_fail++; $display("FAIL sat_latency[%0d]: got %0d expected %0d", i, lat, LAT);
         end
         n_tests++;
         if (m_tdata !== exp_d) begin
            n_fail++; $display("FAIL sat_data[%0d]: got %0h expected %0h", i, m_tdata, exp_d);
         end
         tick();
      end
   endtask

   task automatic test_reset_midflight();
      int lat;
      int pushed;
      m_tready = 1'b0;
      pushed   = 0;
      // Fill with 4 samples and let the first one park at the stalled output.
      for (int c = 0; c < 20 && !m_tvalid; c++) begin
         s_tvalid = (pushed < 4);
         s_tdata  = int'($urandom_range(0, 16383)) - 8192;
         s_tuser  = 1'b1;
         #1;
         if (s_tvalid && s_tready) pushed++;
         tick();
      end
      s_tvalid = 1'b0;
      n_tests++;
      if (m_tvalid !== 1'b1 || pushed !== 4) begin
         n_fail++; $display("FAIL rst_fill: got valid %0b pushed %0d expected 1 and 4",
                            m_tvalid, pushed);
      end
      #2;
      aresetn = 1'b1;
      #1;
      n_tests++;
      if (m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_async: got valid %0b data %0h expected 0 0",
                            m_tvalid, m_tdata);
      end
      tick();
      aresetn  = 1'b0;
      m_tready = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 32'sd4096;
      s_tuser  = 1'b0;
      tick();
      s_tvalid = 1'b0;
      lat = 1;
      while (!m_tvalid && lat < 20) begin
         tick();
         lat++;
      end
      n_tests++;
      if (lat !== LAT) begin
         n_fail++; $display("FAIL rst_next_latency: got %0d expected %0d", lat, LAT);
      end
      n_tests++;
      if (m_tdata !== 32'd11131 || m_tuser !== 1'b0) begin
         n_fail++; $display("FAIL rst_next_data: got %0d/%0b expected 11131/0", m_tdata, m_tuser);
      end
      tick();
   endtask

   task automatic test_random_stream();
      exp_t        q[$];
      exp_t        e;
      logic        prev_stall;
      logic [31:0] held_d;
      logic        held_u;
      int          errs_before;
      prev_stall = 1'b0; held_d = '0; held_u = 1'b0;
      errs_before = n_fail;
      for (int c = 0; c < 400; c++) begin
         s_tvalid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) s_tdata = $urandom;
         else s_tdata = int'($urandom_range(0, 65535)) - 32768;
         s_tuser  = 1'($urandom);
         m_tready = ($urandom_range(0, 3) != 0);
         #1;
         n_tests++;
         if (s_tready !== (!m_tvalid || m_tready)) begin
            n_fail++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", c, s_tready,
                               !m_tvalid || m_tready);
         end
         if (prev_stall) begin
            n_tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tuser !== held_u) begin
               n_fail++; $display("FAIL rnd_hold[%0d]: got %0b %0h/%0b expected 1 %0h/%0b",
                                  c, m_tvalid, m_tdata, m_tuser, held_d, held_u);
            end
         end
         if (m_tvalid && m_tready) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rnd_spurious[%0d]: got %0h expected no output", c, m_tdata);
            end else begin
               e = q.pop_front();
               if (m_tdata !== e.d || m_tuser !== e.u) begin
                  n_fail++; $display("FAIL rnd_data[%0d]: got %0h/%0b expected %0h/%0b",
                                     c, m_tdata, m_tuser, e.d, e.u);
               end
            end
         end
         if (s_tvalid && s_tready) begin
            e.d = exp_model(s_tdata);
            e.u = s_tuser;
            q.push_back(e);
         end
         prev_stall = m_tvalid && !m_tready;
         held_d     = m_tdata;
         held_u     = m_tuser;
         tick();
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      for (int c = 0; c < 50 && q.size() > 0; c++) begin
         #1;
         if (m_tvalid) begin
            e = q.pop_front();
            n_tests++;
            if (m_tdata !== e.d || m_tuser !== e.u) begin
               n_fail++; $display("FAIL rnd_drain: got %0h/%0b expected %0h/%0b",
                                  m_tdata, m_tuser, e.d, e.u);
            end
         end
         tick();
      end
      n_tests++;
      if (q.size() != 0) begin
         n_fail++; $display("FAIL rnd_leftover: got %0d pending expected 0", q.size());
      end
      if (n_fail != errs_before) $display("[TB] random stream saw %0d errors", n_fail - errs_before);
   endtask

   initial begin
      test_reset();
      test_single_values();
      test_back_to_back();
      test_saturation();
      test_reset_midflight();
      test_random_stream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
